// File: rtl/spatz_l1d_maint_arbiter.sv
// spatz_l1d_maint_arbiter
//   Shares the L1D maintenance port (flush / invalidate) among NrReq requesters.
//   Round-robin grant, one operation in flight, per-requester completion pulse.
//
// Ports
//   clk_i, rst_i        clock, asynchronous active-high reset
//   req_valid_i         per-requester request pending
//   req_insn_i          per-requester opcode, packed [i*InsnWidth +: InsnWidth]
//   req_ready_o         one-hot acceptance (IDLE only)
//   done_o              one-cycle completion pulse to the owner
//   l1d_insn_o          opcode to the cache (0 in IDLE, latched opcode otherwise)
//   l1d_insn_valid_o    one-cycle issue strobe
//   l1d_insn_ready_i    cache completion strobe
//   l1d_busy_o          high whenever not IDLE
//   timeout_o           sticky watchdog flag
//
// Configuration
//   SPATZ_L1D_MAINT_TIMEOUT_EN: enables the WAIT watchdog (TimeoutCycles). Without it WAIT
//   waits indefinitely and timeout_o is tied to 0.
module spatz_l1d_maint_arbiter #(
  parameter int unsigned NrReq         = 4,
  parameter int unsigned InsnWidth     = 2,
  parameter int unsigned TimeoutCycles = 4096
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [NrReq-1:0]           req_valid_i,
  input  logic [NrReq*InsnWidth-1:0] req_insn_i,
  output logic [NrReq-1:0]           req_ready_o,
  output logic [NrReq-1:0]           done_o,
  output logic [InsnWidth-1:0]       l1d_insn_o,
  output logic                       l1d_insn_valid_o,
  input  logic                       l1d_insn_ready_i,
  output logic                       l1d_busy_o,
  output logic                       timeout_o
);

  localparam int unsigned IdxW = (NrReq > 1) ? $clog2(NrReq) : 1;
  localparam logic [InsnWidth-1:0] InsnReserved = {InsnWidth{1'b1}};

  if (NrReq < 2 || InsnWidth < 2 || TimeoutCycles < 2) begin : gen_param_check
    $error("spatz_l1d_maint_arbiter: illegal parameterisation");
  end

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

  state_e               state_q, state_d;
  logic [IdxW-1:0]      rr_q, rr_d;
  logic [IdxW-1:0]      owner_q, owner_d;
  logic [InsnWidth-1:0] insn_q, insn_d;

  logic            gnt_found;
  logic [IdxW-1:0] gnt_idx;
  logic [IdxW-1:0] cand;
  logic            timeout_hit;

  // First valid requester at or after the rr pointer, wrapping.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int k = 0; k < int'(NrReq); k++) begin
      cand = IdxW'((int'(rr_q) + k) % int'(NrReq));
      if (!gnt_found && req_valid_i[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

`ifdef SPATZ_L1D_MAINT_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TimeoutCycles + 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            timeout_q, timeout_d;

  assign timeout_hit = (state_q == StWait) && (cnt_q == CntW'(TimeoutCycles - 1));

  always_comb begin
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    // WAIT is only ever entered from ISSUE, so clearing there covers every entry.
    if (state_q == StIssue) begin
      cnt_d = '0;
    end else if (state_q == StWait) begin
      cnt_d = cnt_q + 1'b1;
    end
    if (timeout_hit && !l1d_insn_ready_i) begin
      timeout_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout_o = timeout_q;
`else
  assign timeout_hit = 1'b0;
  assign timeout_o   = 1'b0;
`endif

  always_comb begin
    state_d          = state_q;
    rr_d             = rr_q;
    owner_d          = owner_q;
    insn_d           = insn_q;
    req_ready_o      = '0;
    done_o           = '0;
    l1d_insn_valid_o = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (gnt_found) begin
          req_ready_o[gnt_idx] = 1'b1;
          owner_d = gnt_idx;
          insn_d  = req_insn_i[int'(gnt_idx)*InsnWidth +: InsnWidth];
          rr_d    = (gnt_idx == IdxW'(NrReq - 1)) ? '0 : gnt_idx + 1'b1;
          // Reserved opcode is acknowledged without touching the cache.
          state_d = (insn_d == InsnReserved) ? StDone : StIssue;
        end
      end
      StIssue: begin
        l1d_insn_valid_o = 1'b1;
        state_d = l1d_insn_ready_i ? StDone : StWait;
      end
      StWait: begin
        if (l1d_insn_ready_i || timeout_hit) begin
          state_d = StDone;
        end
      end
      StDone: begin
        done_o[owner_q] = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      rr_q    <= '0;
      owner_q <= '0;
      insn_q  <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      owner_q <= owner_d;
      insn_q  <= insn_d;
    end
  end

  assign l1d_busy_o = (state_q != StIdle);
  assign l1d_insn_o = (state_q == StIdle) ? '0 : insn_q;

endmodule

// File: tb/tb_spatz_l1d_maint_arbiter.sv
module tb_spatz_l1d_maint_arbiter;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic [3:0] req_valid_i = '0;
  logic [7:0] req_insn_i = '0;
  logic [3:0] req_ready_o;
  logic [3:0] done_o;
  logic [1:0] l1d_insn_o;
  logic       l1d_insn_valid_o;
  logic       l1d_insn_ready_i = 1'b0;
  logic       l1d_busy_o;
  logic       timeout_o;

  int total = 0;
  int bad = 0;

  spatz_l1d_maint_arbiter #(
    .NrReq(4),
    .InsnWidth(2),
    .TimeoutCycles(16)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .req_valid_i(req_valid_i),
    .req_insn_i(req_insn_i),
    .req_ready_o(req_ready_o),
    .done_o(done_o),
    .l1d_insn_o(l1d_insn_o),
    .l1d_insn_valid_o(l1d_insn_valid_o),
    .l1d_insn_ready_i(l1d_insn_ready_i),
    .l1d_busy_o(l1d_busy_o),
    .timeout_o(timeout_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic cyc();
    @(posedge clk_i);
    #2;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    req_valid_i = '0;
    req_insn_i = '0;
    l1d_insn_ready_i = 1'b0;
    cyc();
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    cyc();
    #1;
    total++;
    if ({req_ready_o, done_o, l1d_insn_o, l1d_insn_valid_o, l1d_busy_o, timeout_o} !== 13'd0) begin
      bad++;
      $display("FAIL reset_outputs: got %b want 0", {req_ready_o, done_o, l1d_insn_o,
               l1d_insn_valid_o, l1d_busy_o, timeout_o});
    end
  endtask

  task automatic test_single();
    do_reset();
    req_valid_i = 4'b0100;
    req_insn_i = 8'b00_01_00_00;
    #1;
    total++;
    if (req_ready_o !== 4'b0100) begin
      bad++; $display("FAIL single_grant: got %b want 0100", req_ready_o);
    end
    total++;
    if (l1d_busy_o !== 1'b0) begin
      bad++; $display("FAIL single_busy_idle: got %b want 0", l1d_busy_o);
    end
    cyc();
    req_valid_i = '0;
    #1;
    total++;
    if ({l1d_insn_valid_o, l1d_insn_o, l1d_busy_o, req_ready_o} !== 8'b1_01_1_0000) begin
      bad++; $display("FAIL single_issue: got %b want 10110000",
                      {l1d_insn_valid_o, l1d_insn_o, l1d_busy_o, req_ready_o});
    end
    repeat (3) begin
      cyc();
      #1;
      total++;
      if ({l1d_insn_valid_o, l1d_insn_o, done_o} !== 7'b0_01_0000) begin
        bad++; $display("FAIL single_wait: got %b want 0010000", {l1d_insn_valid_o, l1d_insn_o, done_o});
      end
    end
    cyc();
    l1d_insn_ready_i = 1'b1;
    #1;
    total++;
    if (done_o !== 4'b0000) begin
      bad++; $display("FAIL single_ready_cycle_done: got %b want 0000", done_o);
    end
    cyc();
    l1d_insn_ready_i = 1'b0;
    #1;
    total++;
    if ({done_o, l1d_busy_o} !== 5'b0100_1) begin
      bad++; $display("FAIL single_done: got %b want 01001", {done_o, l1d_busy_o});
    end
    cyc();
    #1;
    total++;
    if ({done_o, l1d_busy_o, l1d_insn_o} !== 7'b0000_0_00) begin
      bad++; $display("FAIL single_back_idle: got %b want 0000000", {done_o, l1d_busy_o, l1d_insn_o});
    end
  endtask

  task automatic test_contention();
    logic [3:0] exp;
    do_reset();
    req_insn_i = '0;
    req_valid_i = 4'hf;
    for (int op = 0; op < 5; op++) begin
      exp = 4'b0001 << (op % 4);
      #1;
      total++;
      if (req_ready_o !== exp) begin
        bad++; $display("FAIL contention_grant%0d: got %b want %b", op, req_ready_o, exp);
      end
      cyc();
      #1;
      total++;
      if ({l1d_insn_valid_o, req_ready_o} !== 5'b1_0000) begin
        bad++; $display("FAIL contention_issue%0d: got %b want 10000", op, {l1d_insn_valid_o, req_ready_o});
      end
      cyc();
      #1;
      total++;
      if (req_ready_o !== 4'b0000) begin
        bad++; $display("FAIL contention_no_double%0d: got %b want 0000", op, req_ready_o);
      end
      cyc();
      cyc();
      l1d_insn_ready_i = 1'b1;
      cyc();
      l1d_insn_ready_i = 1'b0;
      #1;
      total++;
      if ({done_o, req_ready_o} !== {exp, 4'b0000}) begin
        bad++; $display("FAIL contention_done%0d: got %b want %b0000", op, {done_o, req_ready_o}, exp);
      end
      cyc();
    end
    req_valid_i = '0;
  endtask

  task automatic test_same_cycle();
    do_reset();
    req_valid_i = 4'b0001;
    req_insn_i = 8'b00_00_00_10;
    cyc();
    req_valid_i = '0;
    l1d_insn_ready_i = 1'b1;
    #1;
    total++;
    if ({l1d_insn_valid_o, l1d_insn_o} !== 3'b1_10) begin
      bad++; $display("FAIL same_cycle_issue: got %b want 110", {l1d_insn_valid_o, l1d_insn_o});
    end
    cyc();
    l1d_insn_ready_i = 1'b0;
    #1;
    total++;
    if ({done_o, l1d_insn_valid_o} !== 5'b0001_0) begin
      bad++; $display("FAIL same_cycle_done: got %b want 00010", {done_o, l1d_insn_valid_o});
    end
  endtask

  task automatic test_reserved();
    do_reset();
    req_valid_i = 4'b0010;
    req_insn_i = 8'b00_00_11_00;
    #1;
    total++;
    if ({req_ready_o, l1d_insn_valid_o} !== 5'b0010_0) begin
      bad++; $display("FAIL reserved_grant: got %b want 00100", {req_ready_o, l1d_insn_valid_o});
    end
    cyc();
    req_valid_i = '0;
    #1;
    total++;
    if ({done_o, l1d_insn_valid_o, l1d_insn_o} !== 7'b0010_0_11) begin
      bad++; $display("FAIL reserved_done: got %b want 0010011", {done_o, l1d_insn_valid_o, l1d_insn_o});
    end
    cyc();
    #1;
    total++;
    if ({done_o, l1d_busy_o, l1d_insn_valid_o} !== 6'b0000_0_0) begin
      bad++; $display("FAIL reserved_idle: got %b want 000000", {done_o, l1d_busy_o, l1d_insn_valid_o});
    end
  endtask

  task automatic test_spurious_and_reset();
    do_reset();
    l1d_insn_ready_i = 1'b1;
    repeat (2) begin
      cyc();
      #1;
      total++;
      if ({done_o, l1d_busy_o} !== 5'b0000_0) begin
        bad++; $display("FAIL spurious_ready: got %b want 00000", {done_o, l1d_busy_o});
      end
    end
    l1d_insn_ready_i = 1'b0;
    // Grant requester 1 so the pointer moves to 2, then reset while in WAIT.
    req_valid_i = 4'b0010;
    req_insn_i = 8'b00_00_01_00;
    cyc();
    req_valid_i = '0;
    cyc();
    rst_i = 1'b1;
    #1;
    total++;
    if ({req_ready_o, done_o, l1d_insn_o, l1d_insn_valid_o, l1d_busy_o, timeout_o} !== 13'd0) begin
      bad++; $display("FAIL reset_in_wait: got %b want 0", {req_ready_o, done_o, l1d_insn_o,
                      l1d_insn_valid_o, l1d_busy_o, timeout_o});
    end
    cyc();
    rst_i = 1'b0;
    req_valid_i = 4'b1010;
    #1;
    total++;
    if (req_ready_o !== 4'b0010) begin
      bad++; $display("FAIL reset_pointer: got %b want 0010", req_ready_o);
    end
    cyc();
    req_valid_i = '0;
  endtask

  task automatic test_timeout();
    do_reset();
    req_valid_i = 4'b0100;
    req_insn_i = 8'b00_00_00_00;
    cyc();
    req_valid_i = '0;
`ifdef SPATZ_L1D_MAINT_TIMEOUT_EN
    repeat (16) cyc();
    #1;
    total++;
    if ({done_o, timeout_o} !== 5'b0000_0) begin
      bad++; $display("FAIL timeout_last_wait: got %b want 00000", {done_o, timeout_o});
    end
    cyc();
    #1;
    total++;
    if ({done_o, timeout_o} !== 5'b0100_1) begin
      bad++; $display("FAIL timeout_done: got %b want 01001", {done_o, timeout_o});
    end
    cyc();
    l1d_insn_ready_i = 1'b1;
    cyc();
    l1d_insn_ready_i = 1'b0;
    #1;
    total++;
    if ({done_o, l1d_busy_o, timeout_o} !== 6'b0000_0_1) begin
      bad++; $display("FAIL timeout_late_ready: got %b want 000001", {done_o, l1d_busy_o, timeout_o});
    end
`else
    repeat (20) cyc();
    #1;
    total++;
    if ({done_o, l1d_busy_o, timeout_o} !== 6'b0000_1_0) begin
      bad++; $display("FAIL no_timeout_wait: got %b want 000010", {done_o, l1d_busy_o, timeout_o});
    end
    l1d_insn_ready_i = 1'b1;
    cyc();
    l1d_insn_ready_i = 1'b0;
    #1;
    total++;
    if ({done_o, timeout_o} !== 5'b0100_0) begin
      bad++; $display("FAIL no_timeout_done: got %b want 01000", {done_o, timeout_o});
    end
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_same_cycle();
    test_reserved();
    test_spurious_and_reset();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
